ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage plus EX/MEM pipeline register. Consumes ID/EX register outputs, resolves
//  operands via MEM/WB forwarding, computes the ALU result (single-cycle ops, 32-cycle
//  iterative MUL), and registers results for the memory stage.
//  Asserts ex_stall upstream while MUL is in progress.
// PARAMETERS
//  XLEN      32  datapath width
//  MUL_ITERS 32  shift-add iterations for MUL; equals XLEN
// PORTS
//  clk             in   1     clock; all state updates on rising edge
//  reset           in   1     asynchronous, active-low reset
//  data_1_in       in   XLEN  rs1 value from ID/EX
//  data_2_in       in   XLEN  rs2 value from ID/EX
//  rs1_in, rs2_in  in   5     source register indices from ID/EX
//  Rd_in           in   5     destination register index
//  ALU_ctrl_in     in   4     operation; encoding given under BEHAVIOUR
//  ALU_src_in      in   1     1: operand B = imm_in; 0: operand B = forwarded rs2
//  imm_in          in   XLEN  immediate
//  auipc_in        in   1     1: operand A = PC_in
//  PC_in           in   XLEN  instruction PC
//  MEM_wen_in, WB_sel_in, Reg_WB_in  in 1  control bits, passed through
//  wb_Rd, wb_Reg_WB, wb_data  in 5/1/XLEN  WB-stage forwarding source
//  flush           in   1     kill the instruction in EX (branch redirect)
//  ALU_out         out  XLEN  registered result
//  store_data_out  out  XLEN  registered forwarded rs2 value for stores
//  Rd_out          out  5     registered destination index
//  MEM_wen_out, WB_sel_out, Reg_WB_out  out 1  registered control bits
//  ex_stall        out  1     combinational; upstream holds PC/IF/ID/ID-EX while high
// BEHAVIOUR
//  Reset (reset=0, async): all outputs and registers = 0; FSM = IDLE.
//  ALU_ctrl: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU,
//   10 MUL (low XLEN bits), 11 PASS_B. Codes 12-15 produce result 0.
//   Shift amount = B[4:0]. Arithmetic wraps modulo 2^XLEN.
//  Forwarding, per source, with MEM taking priority over WB:
//   MEM forward when Reg_WB_out && !WB_sel_out && Rd_out!=0 && Rd_out==rsX_in.
//    Value forwarded: ALU_out.
//   WB forward when wb_Reg_WB && wb_Rd!=0 && wb_Rd==rsX_in. Value forwarded: wb_data.
//   Otherwise: data_X_in.
//   Register x0 is never forwarded.
//  Single-cycle ops: 1-cycle latency. EX/MEM loads on each edge while in IDLE with
//   ex_stall=0.
//  MUL FSM:
//   IDLE: ALU_ctrl_in==10 && !flush ->
//    ex_stall=1 combinationally; latch A, B, Rd and control bits; counter=0; go to BUSY.
//    The EX/MEM register loads a bubble (Reg_WB/MEM_wen=0).
//   BUSY: ex_stall=1. Performs one shift-add step per cycle. EX/MEM loads a bubble.
//    After MUL_ITERS steps, go to DONE.
//   DONE: ex_stall=0. EX/MEM loads the product with the latched Rd and control bits.
//    Go to IDLE. The MUL instruction leaves ID/EX on this same edge.
//   Total: 34 cycles from the MUL entering EX until its result is in EX/MEM.
//   Operands are fixed at latch time; later changes to forwarding sources are ignored.
//  flush=1: EX/MEM loads a bubble (all outputs 0).
//   A MUL in BUSY or DONE is aborted; FSM goes to IDLE; ex_stall deasserts the same cycle.
//   flush overrides a MUL start in IDLE.
//  Reset mid-MUL: FSM returns immediately to IDLE; no result is written.
//  A bubble clears every EX/MEM output field to 0, including ALU_out.
// STRUCTURE
//  Shared package rv_pkg: ALU_ctrl localparams (ALU_ADD..ALU_PASSB), XLEN, and the FSM
//   state enum {IDLE, BUSY, DONE}.
//  One sub-module, iter_mul: handles start, busy, done, a, b, product.
//  Forwarding muxes, ALU and EX/MEM register are implemented inline.
// TESTING
//  ADD: A=5, B=imm 7, ALU_src=1, Rd=3, Reg_WB=1 -> next edge: ALU_out=12, Rd_out=3, Reg_WB_out=1.
//  MEM-over-WB priority: previous instr wrote x4=9 (ALU); wb_Rd=4, wb_data=1; next instr SUB x4-x4
//   -> ALU_out=0; operand A taken from MEM (9), not WB (1).
//  MUL 0xFFFFFFFF*3 -> ex_stall high 33 cycles; bubbles in EX/MEM; then ALU_out=0xFFFFFFFD.
//  flush during MUL BUSY cycle 10 -> ex_stall=0 that cycle; EX/MEM bubble; next op executes normally.
//  auipc: PC=0x100, imm=0x1000 -> ALU_out=0x1100. SRA: 0x80000000>>4 -> 0xF8000000.
//  Async reset low mid-MUL, between clock edges -> all outputs 0 immediately; ex_stall=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the execute stage: datapath width, MUL iteration
// count, ALU operation encodings, the iterative multiplier state type and a
// helper that decides whether a pipeline write can be forwarded to a source.
package rv_pkg;

    localparam int XLEN      = 32;
    localparam int MUL_ITERS = 32;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_MUL   = 4'd10;
    localparam logic [3:0] ALU_PASSB = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // A later stage's write is usable for source rs only if it really writes
    // a register and that register is not x0 (x0 always reads as zero).
    function automatic logic fwd_match(input logic       wr_en,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs);
        return wr_en && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/ex_stage_iter_mul.sv
// iter_mul: shift-add multiplier producing the low XLEN bits of a*b.
// One step per clock while BUSY; MUL_ITERS steps, then one DONE cycle in
// which the product is valid.
// Ports:
//   clk      clock
//   reset    asynchronous, active-low
//   start    latch a/b and begin (honoured only in IDLE)
//   abort    drop an operation in progress and return to IDLE
//   a, b     operands, sampled on the start edge only
//   busy     high while iterating
//   done     high for the single cycle the product is valid
//   product  accumulated product
module iter_mul
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CW = $clog2(MUL_ITERS);

    mul_state_e      state_q, state_d;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = BUSY;
            BUSY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (count == CW'(MUL_ITERS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Classic shift-add: the multiplicand moves left while the multiplier
    // moves right, so bit 0 of the multiplier selects each partial product.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (state_q == IDLE && start) begin
            count  <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (state_q == BUSY && !abort) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

    assign busy    = (state_q == BUSY);
    assign done    = (state_q == DONE);
    assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage plus the EX/MEM pipeline register.
// Resolves rs1/rs2 through MEM and WB forwarding, runs the single-cycle ALU
// or the iterative multiplier, and registers the result for the memory stage.
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   data_1_in, data_2_in       rs1/rs2 values from ID/EX
//   rs1_in, rs2_in, Rd_in      register indices from ID/EX
//   ALU_ctrl_in                operation select (rv_pkg ALU_* codes)
//   ALU_src_in, imm_in         operand B = imm when ALU_src_in is set
//   auipc_in, PC_in            operand A = PC when auipc_in is set
//   MEM_wen_in, WB_sel_in, Reg_WB_in   control bits carried to MEM
//   wb_Rd, wb_Reg_WB, wb_data  WB-stage forwarding source
//   flush                      kill the instruction in EX
//   ALU_out .. Reg_WB_out      EX/MEM register outputs
//   ex_stall                   hold upstream stages while MUL runs
module ex_stage
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] data_1_in,
    input  logic [XLEN-1:0] data_2_in,
    input  logic [4:0]      rs1_in,
    input  logic [4:0]      rs2_in,
    input  logic [4:0]      Rd_in,
    input  logic [3:0]      ALU_ctrl_in,
    input  logic            ALU_src_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic            auipc_in,
    input  logic [XLEN-1:0] PC_in,
    input  logic            MEM_wen_in,
    input  logic            WB_sel_in,
    input  logic            Reg_WB_in,
    input  logic [4:0]      wb_Rd,
    input  logic            wb_Reg_WB,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic [XLEN-1:0] ALU_out,
    output logic [XLEN-1:0] store_data_out,
    output logic [4:0]      Rd_out,
    output logic            MEM_wen_out,
    output logic            WB_sel_out,
    output logic            Reg_WB_out,
    output logic            ex_stall
);

    logic            mem_fwd_1, mem_fwd_2, wb_fwd_1, wb_fwd_2;
    logic [XLEN-1:0] rs1_val, rs2_val, op_a, op_b, alu_result;
    logic [4:0]      shamt;
    logic            mul_busy, mul_done, mul_idle, mul_start;
    logic [XLEN-1:0] mul_product, mul_store;
    logic [4:0]      mul_rd;
    logic            mul_mem_wen, mul_wb_sel, mul_reg_wb;

    // A load in MEM (WB_sel_out set) has no data yet, so only ALU results
    // are forwarded from MEM. MEM is newer than WB and therefore wins.
    assign mem_fwd_1 = fwd_match(Reg_WB_out && !WB_sel_out, Rd_out, rs1_in);
    assign mem_fwd_2 = fwd_match(Reg_WB_out && !WB_sel_out, Rd_out, rs2_in);
    assign wb_fwd_1  = fwd_match(wb_Reg_WB, wb_Rd, rs1_in);
    assign wb_fwd_2  = fwd_match(wb_Reg_WB, wb_Rd, rs2_in);

    assign rs1_val = mem_fwd_1 ? ALU_out : (wb_fwd_1 ? wb_data : data_1_in);
    assign rs2_val = mem_fwd_2 ? ALU_out : (wb_fwd_2 ? wb_data : data_2_in);

    assign op_a  = auipc_in   ? PC_in  : rs1_val;
    assign op_b  = ALU_src_in ? imm_in : rs2_val;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_result = '0;
        case (ALU_ctrl_in)
            ALU_ADD:   alu_result = op_a + op_b;
            ALU_SUB:   alu_result = op_a - op_b;
            ALU_AND:   alu_result = op_a & op_b;
            ALU_OR:    alu_result = op_a | op_b;
            ALU_XOR:   alu_result = op_a ^ op_b;
            ALU_SLL:   alu_result = op_a << shamt;
            ALU_SRL:   alu_result = op_a >> shamt;
            ALU_SRA:   alu_result = $unsigned($signed(op_a) >>> shamt);
            ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_PASSB: alu_result = op_b;
            default:   alu_result = '0;
        endcase
    end

    // The start term is gated by reset so that an asserted reset drops the
    // stall immediately even while ID/EX still holds a MUL.
    assign mul_idle  = !mul_busy && !mul_done;
    assign mul_start = reset && mul_idle && (ALU_ctrl_in == ALU_MUL) && !flush;
    assign ex_stall  = mul_start || (mul_busy && !flush);

    iter_mul u_iter_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .abort   (flush),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Destination and control of the MUL are captured at start so that the
    // result is written back with them even if forwarding sources move on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_rd      <= '0;
            mul_mem_wen <= 1'b0;
            mul_wb_sel  <= 1'b0;
            mul_reg_wb  <= 1'b0;
            mul_store   <= '0;
        end else if (mul_start) begin
            mul_rd      <= Rd_in;
            mul_mem_wen <= MEM_wen_in;
            mul_wb_sel  <= WB_sel_in;
            mul_reg_wb  <= Reg_WB_in;
            mul_store   <= rs2_val;
        end
    end

    // EX/MEM register: bubbles are all-zero, including ALU_out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ALU_out        <= '0;
            store_data_out <= '0;
            Rd_out         <= '0;
            MEM_wen_out    <= 1'b0;
            WB_sel_out     <= 1'b0;
            Reg_WB_out     <= 1'b0;
        end else if (flush || mul_start || mul_busy) begin
            ALU_out        <= '0;
            store_data_out <= '0;
            Rd_out         <= '0;
            MEM_wen_out    <= 1'b0;
            WB_sel_out     <= 1'b0;
            Reg_WB_out     <= 1'b0;
        end else if (mul_done) begin
            ALU_out        <= mul_product;
            store_data_out <= mul_store;
            Rd_out         <= mul_rd;
            MEM_wen_out    <= mul_mem_wen;
            WB_sel_out     <= mul_wb_sel;
            Reg_WB_out     <= mul_reg_wb;
        end else begin
            ALU_out        <= alu_result;
            store_data_out <= rs2_val;
            Rd_out         <= Rd_in;
            MEM_wen_out    <= MEM_wen_in;
            WB_sel_out     <= WB_sel_in;
            Reg_WB_out     <= Reg_WB_in;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage. Directed instructions are issued one per cycle;
// each expected EX/MEM result is queued with the cycle it must appear in,
// and a negedge monitor compares whenever the DUT presents a live result.
module tb_ex_stage;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_1_in, data_2_in, imm_in, PC_in, wb_data;
    logic [4:0]  rs1_in, rs2_in, Rd_in, wb_Rd;
    logic [3:0]  ALU_ctrl_in;
    logic        ALU_src_in, auipc_in, MEM_wen_in, WB_sel_in, Reg_WB_in;
    logic        wb_Reg_WB, flush;
    logic [31:0] ALU_out, store_data_out;
    logic [4:0]  Rd_out;
    logic        MEM_wen_out, WB_sel_out, Reg_WB_out, ex_stall;

    ex_stage dut (
        .clk            (clk),
        .reset          (reset),
        .data_1_in      (data_1_in),
        .data_2_in      (data_2_in),
        .rs1_in         (rs1_in),
        .rs2_in         (rs2_in),
        .Rd_in          (Rd_in),
        .ALU_ctrl_in    (ALU_ctrl_in),
        .ALU_src_in     (ALU_src_in),
        .imm_in         (imm_in),
        .auipc_in       (auipc_in),
        .PC_in          (PC_in),
        .MEM_wen_in     (MEM_wen_in),
        .WB_sel_in      (WB_sel_in),
        .Reg_WB_in      (Reg_WB_in),
        .wb_Rd          (wb_Rd),
        .wb_Reg_WB      (wb_Reg_WB),
        .wb_data        (wb_data),
        .flush          (flush),
        .ALU_out        (ALU_out),
        .store_data_out (store_data_out),
        .Rd_out         (Rd_out),
        .MEM_wen_out    (MEM_wen_out),
        .WB_sel_out     (WB_sel_out),
        .Reg_WB_out     (Reg_WB_out),
        .ex_stall       (ex_stall)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        src;
        logic [31:0] imm;
        logic        auipc;
        logic [31:0] pc;
        logic        memw;
        logic        wbsel;
        logic        regwb;
        logic [4:0]  wbrd;
        logic        wbregwb;
        logic [31:0] wbdata;
        logic        flush;
    } instr_t;

    typedef struct {
        int          cyc;
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        memw;
        logic        wbsel;
        logic        regwb;
    } exp_t;

    exp_t sbQueue[$];
    exp_t sbEntry;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic instr_t mkOp(input logic [3:0] ctrl, input logic [31:0] a,
                                    input logic [31:0] b, input logic src,
                                    input logic [31:0] imm, input logic [4:0] rd);
        instr_t t = '0;
        t.ctrl  = ctrl;
        t.a     = a;
        t.b     = b;
        t.src   = src;
        t.imm   = imm;
        t.rd    = rd;
        t.regwb = 1'b1;
        return t;
    endfunction

    task automatic driveInputs(input instr_t t);
        ALU_ctrl_in = t.ctrl;
        data_1_in   = t.a;
        data_2_in   = t.b;
        rs1_in      = t.rs1;
        rs2_in      = t.rs2;
        Rd_in       = t.rd;
        ALU_src_in  = t.src;
        imm_in      = t.imm;
        auipc_in    = t.auipc;
        PC_in       = t.pc;
        MEM_wen_in  = t.memw;
        WB_sel_in   = t.wbsel;
        Reg_WB_in   = t.regwb;
        wb_Rd       = t.wbrd;
        wb_Reg_WB   = t.wbregwb;
        wb_data     = t.wbdata;
        flush       = t.flush;
    endtask

    task automatic pushExpect(input int cyc, input logic [31:0] alu,
                              input logic [31:0] store, input instr_t t);
        exp_t e;
        e.cyc   = cyc;
        e.alu   = alu;
        e.store = store;
        e.rd    = t.rd;
        e.memw  = t.memw;
        e.wbsel = t.wbsel;
        e.regwb = t.regwb;
        sbQueue.push_back(e);
    endtask

    // Issue one instruction; its result must be in EX/MEM after the next edge.
    task automatic applyStimulus(input instr_t t, input logic [31:0] expAlu,
                                 input logic [31:0] expStore);
        driveInputs(t);
        pushExpect(cycle + 1, expAlu, expStore, t);
        tick();
    endtask

    // Monitor: any EX/MEM entry with a live control bit is a real result.
    always @(negedge clk) begin
        if (reset === 1'b1 && (Reg_WB_out || MEM_wen_out || WB_sel_out)) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected: got ALU_out=0x%08h Rd_out=%0d with nothing expected (cycle %0d)",
                         ALU_out, Rd_out, cycle);
            end else begin
                sbEntry = sbQueue.pop_front();
                checkOutput("sb_cycle", cycle, sbEntry.cyc);
                checkOutput("sb_alu", ALU_out, sbEntry.alu);
                checkOutput("sb_store", store_data_out, sbEntry.store);
                checkOutput("sb_rd", 32'(Rd_out), 32'(sbEntry.rd));
                checkOutput("sb_ctrl", 32'({MEM_wen_out, WB_sel_out, Reg_WB_out}),
                            32'({sbEntry.memw, sbEntry.wbsel, sbEntry.regwb}));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        instr_t t;
        int     stallCycles;

        reset = 1'b0;
        driveInputs('0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_alu", ALU_out, 32'd0);
        checkOutput("reset_store", store_data_out, 32'd0);
        checkOutput("reset_rd", 32'(Rd_out), 32'd0);
        checkOutput("reset_ctrl", 32'({MEM_wen_out, WB_sel_out, Reg_WB_out}), 32'd0);
        checkOutput("reset_stall", 32'(ex_stall), 32'd0);
        reset = 1'b1;

        // ADD with immediate
        t = mkOp(ALU_ADD, 32'd5, 32'd0, 1'b1, 32'd7, 5'd3);
        applyStimulus(t, 32'd12, 32'd0);

        // MEM-over-WB priority
        t = mkOp(ALU_ADD, 32'd9, 32'd0, 1'b1, 32'd0, 5'd4); t.rs1 = 5'd1;
        applyStimulus(t, 32'd9, 32'd0);
        t = mkOp(ALU_SUB, 32'd100, 32'd200, 1'b0, 32'd0, 5'd5);
        t.rs1 = 5'd4; t.rs2 = 5'd4; t.wbrd = 5'd4; t.wbregwb = 1'b1; t.wbdata = 32'd1;
        applyStimulus(t, 32'd0, 32'd9);
        t = mkOp(ALU_ADD, 32'd9, 32'd0, 1'b1, 32'd0, 5'd4);
        applyStimulus(t, 32'd9, 32'd0);
        t = mkOp(ALU_SUB, 32'd100, 32'd2, 1'b0, 32'd0, 5'd6);
        t.rs1 = 5'd4; t.rs2 = 5'd6; t.wbrd = 5'd4; t.wbregwb = 1'b1; t.wbdata = 32'd1;
        applyStimulus(t, 32'd7, 32'd2);

        // WB-only forward
        t = mkOp(ALU_OR, 32'h99, 32'd0, 1'b1, 32'd3, 5'd8);
        t.rs1 = 5'd7; t.wbrd = 5'd7; t.wbregwb = 1'b1; t.wbdata = 32'h20;
        applyStimulus(t, 32'h23, 32'd0);

        // Load in MEM is not forwarded
        t = mkOp(ALU_ADD, 32'h40, 32'd0, 1'b1, 32'd0, 5'd9); t.wbsel = 1'b1;
        applyStimulus(t, 32'h40, 32'd0);
        t = mkOp(ALU_ADD, 32'h77, 32'd0, 1'b1, 32'd1, 5'd10); t.rs1 = 5'd9;
        applyStimulus(t, 32'h78, 32'd0);

        // x0 never forwarded from MEM or WB
        t = mkOp(ALU_ADD, 32'h11, 32'd0, 1'b1, 32'd0, 5'd0);
        applyStimulus(t, 32'h11, 32'd0);
        t = mkOp(ALU_ADD, 32'd5, 32'd0, 1'b1, 32'd0, 5'd11);
        t.wbrd = 5'd0; t.wbregwb = 1'b1; t.wbdata = 32'hDEAD;
        applyStimulus(t, 32'd5, 32'd0);

        // ALU operation table
        applyStimulus(mkOp(ALU_SRA, 32'h8000_0000, 32'd0, 1'b1, 32'd4, 5'd13), 32'hF800_0000, 32'd0);
        applyStimulus(mkOp(ALU_SRL, 32'h8000_0000, 32'd0, 1'b1, 32'd4, 5'd14), 32'h0800_0000, 32'd0);
        applyStimulus(mkOp(ALU_SLL, 32'd1, 32'd0, 1'b1, 32'd31, 5'd15), 32'h8000_0000, 32'd0);
        applyStimulus(mkOp(ALU_SLL, 32'd1, 32'd0, 1'b1, 32'h24, 5'd16), 32'h10, 32'd0);
        applyStimulus(mkOp(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 5'd17), 32'd1, 32'd1);
        applyStimulus(mkOp(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 5'd18), 32'd0, 32'd1);
        applyStimulus(mkOp(ALU_XOR, 32'hF0F0, 32'd0, 1'b1, 32'hFF00, 5'd19), 32'h0FF0, 32'd0);
        applyStimulus(mkOp(ALU_AND, 32'hF0F0, 32'd0, 1'b1, 32'hFF00, 5'd21), 32'hF000, 32'd0);
        applyStimulus(mkOp(ALU_PASSB, 32'h55, 32'd0, 1'b1, 32'h1234, 5'd22), 32'h1234, 32'd0);
        applyStimulus(mkOp(4'd12, 32'd3, 32'd4, 1'b0, 32'd0, 5'd23), 32'd0, 32'd4);
        applyStimulus(mkOp(ALU_ADD, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd2, 5'd24), 32'd1, 32'd0);
        t = mkOp(ALU_ADD, 32'd5, 32'd0, 1'b1, 32'h1000, 5'd25);
        t.auipc = 1'b1; t.pc = 32'h100;
        applyStimulus(t, 32'h1100, 32'd0);
        applyStimulus(mkOp(ALU_SUB, 32'd0, 32'd0, 1'b1, 32'd1, 5'd20), 32'hFFFF_FFFF, 32'd0);

        // Store: address plus store data, no register write
        t = mkOp(ALU_ADD, 32'h200, 32'hCAFE, 1'b1, 32'd8, 5'd0);
        t.regwb = 1'b0; t.memw = 1'b1; t.rs2 = 5'd12;
        applyStimulus(t, 32'h208, 32'hCAFE);

        // MUL 0xFFFFFFFF * 3; inputs wiggled mid-run must not matter
        t = mkOp(ALU_MUL, 32'hFFFF_FFFF, 32'd3, 1'b0, 32'd0, 5'd10);
        driveInputs(t);
        #1;
        checkOutput("mul_stall_on_issue", 32'(ex_stall), 32'd1);
        pushExpect(cycle + 34, 32'hFFFF_FFFD, 32'd3, t);
        stallCycles = 0;
        while (ex_stall && stallCycles < 100) begin
            stallCycles++;
            if (stallCycles == 3) begin
                data_1_in = 32'd7;
                data_2_in = 32'd9;
                Rd_in     = 5'd11;
            end
            if (stallCycles == 5) begin
                checkOutput("mul_bubble_alu", ALU_out, 32'd0);
                checkOutput("mul_bubble_regwb", 32'(Reg_WB_out), 32'd0);
            end
            tick();
        end
        checkOutput("mul_stall_cycles", 32'(stallCycles), 32'd33);
        tick();

        // Flush during MUL BUSY
        t = mkOp(ALU_MUL, 32'd6, 32'd7, 1'b0, 32'd0, 5'd12);
        driveInputs(t);
        repeat (10) tick();
        flush = 1'b1;
        #1;
        checkOutput("flush_busy_stall", 32'(ex_stall), 32'd0);
        tick();
        checkOutput("flush_busy_alu", ALU_out, 32'd0);
        checkOutput("flush_busy_regwb", 32'(Reg_WB_out), 32'd0);
        applyStimulus(mkOp(ALU_ADD, 32'd1, 32'd0, 1'b1, 32'd2, 5'd13), 32'd3, 32'd0);

        // Flush overriding a MUL start
        applyStimulus(mkOp(ALU_ADD, 32'h10, 32'd0, 1'b1, 32'd0, 5'd26), 32'h10, 32'd0);
        t = mkOp(ALU_MUL, 32'd6, 32'd7, 1'b0, 32'd0, 5'd27); t.flush = 1'b1;
        driveInputs(t);
        #1;
        checkOutput("flush_start_stall", 32'(ex_stall), 32'd0);
        tick();
        checkOutput("flush_start_alu", ALU_out, 32'd0);
        checkOutput("flush_start_regwb", 32'(Reg_WB_out), 32'd0);
        applyStimulus(mkOp(ALU_ADD, 32'd2, 32'd0, 1'b1, 32'd2, 5'd14), 32'd4, 32'd0);

        // Asynchronous reset between edges while MUL is busy
        driveInputs(mkOp(ALU_MUL, 32'd5, 32'd5, 1'b0, 32'd0, 5'd15));
        repeat (4) tick();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_mul_stall", 32'(ex_stall), 32'd0);
        checkOutput("rst_mul_alu", ALU_out, 32'd0);
        checkOutput("rst_mul_rd", 32'(Rd_out), 32'd0);
        checkOutput("rst_mul_regwb", 32'(Reg_WB_out), 32'd0);
        driveInputs('0);
        tick();
        reset = 1'b1;
        repeat (40) tick();

        // Recovery, then reset clearing a live result
        applyStimulus(mkOp(ALU_ADD, 32'h30, 32'd0, 1'b1, 32'hC, 5'd16), 32'h3C, 32'd0);
        #4;
        reset = 1'b0;
        #1;
        checkOutput("rst_live_alu", ALU_out, 32'd0);
        checkOutput("rst_live_rd", 32'(Rd_out), 32'd0);
        checkOutput("rst_live_regwb", 32'(Reg_WB_out), 32'd0);

        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
